// File: rtl/bram_stream_reader.sv
// Streams `length` consecutive BRAM words (wrapping modulo DEPTH) from `base_addr`
// onto a valid/ready port, absorbing the one-cycle BRAM read latency in a 4-entry FIFO.
module bram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_read_enable,
    output logic [ADDR_WIDTH-1:0] bram_address,
    input  logic [DATA_WIDTH-1:0] bram_data_out,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int                FIFO_DEPTH = 4;
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = 1;

    state_t                  r_state;
    logic [ADDR_WIDTH:0]     r_length;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic [ADDR_WIDTH:0]     r_sent;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_bram_re;
    logic [ADDR_WIDTH-1:0]   r_bram_addr;
    logic                    r_rd_d1;
    logic [DATA_WIDTH-1:0]   r_fifo_mem [FIFO_DEPTH];
    logic [1:0]              r_wr_ptr;
    logic [1:0]              r_rd_ptr;
    logic [2:0]              r_fifo_count;

    logic [1:0]              w_pending;
    logic                    w_credit;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_last_pop;

    // A read is in flight while presented to the BRAM (r_bram_re) and while its
    // data sits on bram_data_out waiting for the FIFO write (r_rd_d1).
    assign w_pending  = {1'b0, r_bram_re} + {1'b0, r_rd_d1};
    assign w_credit   = ({1'b0, r_fifo_count} + {2'b00, w_pending}) < 4'd4;
    assign w_issue    = (r_state == S_READ) && (r_remaining != '0) && w_credit;
    assign w_push     = r_rd_d1;
    assign w_pop      = m_valid && m_ready;
    assign w_last_pop = w_pop && (r_sent == r_length - LEN_ONE);

    assign busy             = r_busy;
    assign done             = r_done;
    assign bram_read_enable = r_bram_re;
    assign bram_address     = r_bram_addr;
    assign m_valid          = (r_fifo_count != 3'd0);
    assign m_data           = m_valid ? r_fifo_mem[r_rd_ptr] : '0;
    assign m_last           = m_valid && (r_sent == r_length - LEN_ONE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_length    <= '0;
            r_remaining <= '0;
            r_sent      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bram_re   <= 1'b0;
            r_bram_addr <= '0;
            r_rd_d1     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_bram_re <= 1'b0;
            r_rd_d1   <= r_bram_re;
            if (w_pop) begin
                r_sent <= r_sent + LEN_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_length <= length;
                        r_sent   <= '0;
                        r_busy   <= 1'b1;
                        if (length != '0) begin
                            // The accept edge already presents the first read.
                            r_bram_re   <= 1'b1;
                            r_bram_addr <= base_addr;
                            r_remaining <= length - LEN_ONE;
                            r_state     <= S_READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_bram_re   <= 1'b1;
                        r_bram_addr <= r_bram_addr + 1'b1;
                        r_remaining <= r_remaining - LEN_ONE;
                        if (r_remaining == LEN_ONE) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (r_remaining == '0) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_pop) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 3'd1;
                2'b01:   r_fifo_count <= r_fifo_count - 3'd1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an empty FIFO is defined by
    // the count, and m_data is forced to zero whenever nothing is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= bram_data_out;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a registered-read BRAM model
// preloaded with data equal to address.
module tb_bram_stream_reader;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          bram_read_enable;
    logic [AW-1:0] bram_address;
    logic [DW-1:0] bram_data_out;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    logic [DW-1:0] mem [DEPTH];

    int n_cmp  = 0;
    int n_fail = 0;

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .base_addr        (base_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .bram_read_enable (bram_read_enable),
        .bram_address     (bram_address),
        .bram_data_out    (bram_data_out),
        .m_valid          (m_valid),
        .m_data           (m_data),
        .m_last           (m_last),
        .m_ready          (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_read_enable) bram_data_out <= mem[bram_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_re"},    bram_read_enable, 0);
        check({tag, "_addr"},  bram_address, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_last"},  m_last, 0);
        check({tag, "_data"},  m_data, 0);
    endtask

    // Starts a transfer and follows it cycle by cycle. Called and returns at
    // #1 after a rising edge. mode 0: m_ready held high; mode 1: ~1 in 3 high.
    // sp_c >= 0 pulses a stray start at that cycle; abort_n >= 0 raises rst
    // once that many words have been accepted and returns.
    task automatic run_xfer(input int base, input int len, input int mode,
                            input int sp_c, input int abort_n);
        int            c;
        int            idx;
        int            nrd;
        int            last_hs;
        int            done_c;
        bit            finished;
        bit            prev_stall;
        logic [DW-1:0] prev_data;

        base_addr = AW'(base);
        length    = (AW+1)'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 4'd7;
        length    = 5'd5;

        check("accept_busy", busy, 1);
        check("accept_re", bram_read_enable, (len > 0) ? 1 : 0);

        c = 0; idx = 0; nrd = 0; last_hs = -1; done_c = -1;
        finished = 1'b0; prev_stall = 1'b0; prev_data = '0;
        while (!finished && c < 300) begin
            if (abort_n >= 0 && idx == abort_n) begin
                rst = 1'b1;
                return;
            end
            m_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);

            if (bram_read_enable) begin
                check("rd_addr", bram_address, (base + nrd) % DEPTH);
                nrd++;
            end
            check("credit", (nrd - idx) <= 4, 1);
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid) begin
                check("data", m_data, (base + idx) % DEPTH);
                check("last", m_last, (idx == len - 1) ? 1 : 0);
            end
            if (mode == 0) check("no_gap", m_valid, (c >= 2 && c <= len + 1) ? 1 : 0);

            if (done_c >= 0) begin
                check("post_done", done, 0);
                check("post_busy", busy, 0);
                check("reads_total", nrd, len);
                finished = 1'b1;
            end else if (done) begin
                done_c = c;
                check("done_after_last", c, last_hs + 1);
                check("done_words", idx, len);
                check("done_busy", busy, 1);
                if (mode == 0) check("done_cycle", c, (len == 0) ? 0 : len + 2);
            end

            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                idx++;
                last_hs = c;
            end
            start = (c == sp_c);
            if (!finished) begin
                @(posedge clk); #1;
                c++;
            end
        end
        start = 1'b0;
        if (!finished) check("timeout", 0, 1);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        m_ready       = 1'b0;
        base_addr     = '0;
        length        = '0;
        bram_data_out = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b0;
        @(posedge clk); #1;

        run_xfer(0, 16, 0, -1, -1);   // full readback
        run_xfer(14, 4, 0, -1, -1);   // wrap 14,15,0,1
        run_xfer(0, 16, 1, -1, -1);   // backpressure
        run_xfer(0, 0, 0, -1, -1);    // zero length
        run_xfer(2, 8, 0, 3, -1);     // stray start mid-transfer
        check("idle_after_stray", busy, 0);
        @(posedge clk); #1;
        check("stray_no_restart", busy, 0);

        run_xfer(0, 16, 0, -1, 5);    // abort after 5 words
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("mid_rst");
        @(posedge clk); #1;
        check("no_stale_valid", m_valid, 0);
        check("no_stale_re", bram_read_enable, 0);
        run_xfer(3, 2, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
